// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : demux_pkg
// Purpose  : Types and constants shared by the serial frame router and its
//            phase counter.
// Revision : 1.0 - initial release
// ============================================================================
package demux_pkg;

  // Router phases: waiting for start, shifting in the address, then payload.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  localparam int ADDR_BITS = 3;
  localparam int NUM_CH    = 8;

  // Larger of two integers; used to size a counter that serves two phases.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage : demux_pkg
`default_nettype wire

// File: rtl/frame_bit_counter.sv
`default_nettype none
// ============================================================================
// Module   : frame_bit_counter
// Purpose  : Loadable down-counter with a terminal-count flag. Loaded with
//            (length - 1) at the start of a phase; tc_o is high during the
//            final cycle of that phase. Saturates at zero, never wraps.
// Revision : 1.0 - initial release
// ============================================================================
module frame_bit_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: clear beats load, load beats decrement; hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule : frame_bit_counter
`default_nettype wire

// File: rtl/demux_frame_router.sv
`default_nettype none
// ============================================================================
// Module   : demux_frame_router
// Purpose  : Deserialises a frame (3-bit address then DATA_BITS payload bits,
//            both MSB first) and drives a downstream 1:8 demux with a
//            registered channel select and a one-cycle-delayed payload bit.
//            Handles abort, start-while-busy errors and a wrapping frame count.
// Revision : 1.0 - initial release
// ============================================================================
module demux_frame_router
  import demux_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 ser_in,
  input  logic                 abort,
  output logic [ADDR_BITS-1:0] sel,
  output logic                 din,
  output logic                 dout_valid,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 err,
  output logic [7:0]           frame_cnt
);

  // The counter is shared by both phases, so it must hold the larger of the
  // address length and the payload length.
  localparam int CNT_W = max_int($clog2(DATA_BITS + 1), $clog2(ADDR_BITS + 1));
  localparam logic [CNT_W-1:0] LD_ADDR = CNT_W'(ADDR_BITS - 1);
  localparam logic [CNT_W-1:0] LD_DATA = CNT_W'(DATA_BITS - 1);

  state_e                 state_q;
  logic [ADDR_BITS-2:0]   addr_sr_q;   // first address bits; last one joins at the load edge
  logic [ADDR_BITS-1:0]   sel_q;
  logic                   din_q;
  logic                   dout_valid_q;
  logic                   busy_q;
  logic                   frame_done_q;
  logic                   err_q;
  logic [7:0]             frame_cnt_q;

  logic                   ctr_clr;
  logic                   ctr_load;
  logic [CNT_W-1:0]       ctr_load_val;
  logic                   ctr_dec;
  logic                   ctr_tc;
  logic                   in_frame;

  assign in_frame = (state_q != ST_IDLE);

  // Phase counter control: load at the start of ADDR and of DATA, count down
  // while in a frame, clear when a frame is aborted.
  always_comb begin
    ctr_clr      = in_frame && abort;
    ctr_load     = 1'b0;
    ctr_load_val = LD_ADDR;
    ctr_dec      = in_frame && !abort;
    if ((state_q == ST_IDLE) && start && !abort) begin
      ctr_load     = 1'b1;
      ctr_load_val = LD_ADDR;
    end else if ((state_q == ST_ADDR) && !abort && ctr_tc) begin
      ctr_load     = 1'b1;
      ctr_load_val = LD_DATA;
    end
  end

  frame_bit_counter #(
    .WIDTH (CNT_W)
  ) u_bit_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (ctr_clr),
    .load_i     (ctr_load),
    .load_val_i (ctr_load_val),
    .dec_i      (ctr_dec),
    .tc_o       (ctr_tc)
  );

  // Frame FSM with every output registered; pulses default low each cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_sr_q    <= '0;
      sel_q        <= '0;
      din_q        <= 1'b0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      frame_cnt_q  <= 8'd0;
    end else begin
      din_q        <= 1'b0;
      dout_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Abort outranks start, so a simultaneous pair leaves us idle.
          if (start && !abort) begin
            state_q <= ST_ADDR;
            busy_q  <= 1'b1;
          end
        end
        ST_ADDR: begin
          if (abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            err_q     <= start;
            addr_sr_q <= {addr_sr_q[ADDR_BITS-3:0], ser_in};
            if (ctr_tc) begin
              sel_q   <= {addr_sr_q, ser_in};
              state_q <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            err_q        <= start;
            din_q        <= ser_in;
            dout_valid_q <= 1'b1;
            if (ctr_tc) begin
              state_q      <= ST_IDLE;
              busy_q       <= 1'b0;
              frame_done_q <= 1'b1;
              frame_cnt_q  <= frame_cnt_q + 8'd1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sel        = sel_q;
  assign din        = din_q;
  assign dout_valid = dout_valid_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;
  assign frame_cnt  = frame_cnt_q;

endmodule : demux_frame_router
`default_nettype wire
